// File: rtl/ats21_pkg.sv
// rtl/ats21_pkg.sv - shared ATS21 alarm constants and event record (stamp field under ATS21_EVQ_STAMP_EN)
package ats21_pkg;

    localparam int NUM_ALARMS  = 24;
    localparam int ALARM_ID_W  = 5;
    localparam int EVT_STAMP_W = 16;

`ifdef ATS21_EVQ_STAMP_EN
    typedef struct packed {
        logic [ALARM_ID_W-1:0]  id;
        logic [EVT_STAMP_W-1:0] stamp;
    } evt_t;
`else
    typedef struct packed {
        logic [ALARM_ID_W-1:0] id;
    } evt_t;
`endif

    localparam int EVT_W = $bits(evt_t);

endpackage

// File: rtl/ats21_evq_fifo.sv
// rtl/ats21_evq_fifo.sv - synchronous event FIFO with registered head and push+pop when full
module ats21_evq_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 21
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_n;
    logic [CW-1:0] after_pop;
    logic          do_push;
    logic          do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop);
    assign rd_ptr_n  = rd_ptr + AW'(do_pop);
    assign after_pop = count - CW'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // head_data is preloaded with the next head so it holds its last value once empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            head_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr_n;
            count  <= after_pop + CW'(do_push);
            if (after_pop != '0) begin
                head_data <= mem[rd_ptr_n];
            end else if (do_push) begin
                head_data <= push_data;
            end
        end
    end

endmodule

// File: rtl/ats21_event_queue.sv
// rtl/ats21_event_queue.sv - ATS21 alarm edges to ordered event queue; timestamps under ATS21_EVQ_STAMP_EN
module ats21_event_queue #(
    parameter int NUM_ALARMS = ats21_pkg::NUM_ALARMS,
    parameter int DEPTH      = 8,
    parameter int STAMP_W    = ats21_pkg::EVT_STAMP_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_ALARMS-1:0] alarm_data,
    input  logic [NUM_ALARMS-1:0] alarm_mask,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [4:0]            evt_id,
    output logic [STAMP_W-1:0]    evt_stamp,
    output logic                  irq,
    output logic                  overflow,
    input  logic                  ovf_clr,
    output logic [7:0]            lost_cnt
);

    import ats21_pkg::*;

`ifdef ATS21_EVQ_STAMP_EN
    localparam int ENTRY_W = ALARM_ID_W + STAMP_W;
`else
    localparam int ENTRY_W = ALARM_ID_W;
`endif

    logic [NUM_ALARMS-1:0] data_q;
    logic [NUM_ALARMS-1:0] pending;
    logic [NUM_ALARMS-1:0] rise;
    logic [NUM_ALARMS-1:0] low_vec;
    logic [NUM_ALARMS-1:0] push_vec;
    logic [NUM_ALARMS-1:0] lost_vec;
    logic                  armed;
    logic [ALARM_ID_W-1:0] sel_id;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [ENTRY_W-1:0]    push_data;
    logic [ENTRY_W-1:0]    head_data;
    logic [7:0]            n_lost;
    logic [8:0]            lost_sum;

    // armed masks the first cycle after reset so a level already high is not an edge
    assign rise = armed ? (alarm_data & ~data_q & ~alarm_mask) : '0;

    always_comb begin
        sel_id = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_id = ALARM_ID_W'(i);
            end
        end
    end

    assign low_vec   = pending & (~pending + NUM_ALARMS'(1));
    assign evt_valid = ~empty;
    assign pop       = evt_valid & evt_ready;
    assign push      = (|pending) & (~full | pop);
    assign push_vec  = push ? low_vec : '0;
    assign lost_vec  = rise & pending & ~push_vec;
    assign irq       = evt_valid | overflow;

    always_comb begin
        n_lost = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            n_lost = n_lost + 8'(lost_vec[i]);
        end
    end

    // a drop in the same cycle as ovf_clr restarts the count instead of being cleared
    assign lost_sum = (ovf_clr ? 9'd0 : {1'b0, lost_cnt}) + {1'b0, n_lost};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q   <= '0;
            armed    <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
            lost_cnt <= '0;
        end else begin
            data_q  <= alarm_data;
            armed   <= 1'b1;
            pending <= (pending & ~push_vec) | rise;
            if (|lost_vec) begin
                overflow <= 1'b1;
                lost_cnt <= lost_sum[8] ? 8'hFF : lost_sum[7:0];
            end else if (ovf_clr) begin
                overflow <= 1'b0;
                lost_cnt <= '0;
            end
        end
    end

`ifdef ATS21_EVQ_STAMP_EN
    logic [STAMP_W-1:0] tcnt;
    logic [STAMP_W-1:0] stamp [NUM_ALARMS];
    logic [STAMP_W-1:0] sel_stamp;

    always_comb begin
        sel_stamp = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_stamp = stamp[i];
            end
        end
    end

    // a dropped edge keeps the stamp of the event still waiting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                stamp[i] <= '0;
            end
        end else begin
            tcnt <= tcnt + STAMP_W'(1);
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (rise[i] && !lost_vec[i]) begin
                    stamp[i] <= tcnt;
                end
            end
        end
    end

    assign push_data = {sel_id, sel_stamp};
    assign evt_id    = head_data[ENTRY_W-1 -: ALARM_ID_W];
    assign evt_stamp = head_data[STAMP_W-1:0];
`else
    assign push_data = sel_id;
    assign evt_id    = head_data;
    assign evt_stamp = '0;
`endif

    ats21_evq_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .full      (full),
        .empty     (empty),
        .count     ()
    );

endmodule
